// File: rtl/bit_scan_mux.sv
// bit_scan_mux: latches one IWIDTH-bit glyph word and streams OWIDTH-bit slices
// from it, either one slice (random access) or a wrapping scan of COUNT slices.
//
// Ports:
//   clk, rst_n                clock, synchronous active-low reset
//   in_data/in_mode/in_sel    request word, mode (0 single, 1 scan), start slice
//   in_count                  scan length in beats (0 or >BEATS means BEATS)
//   in_valid/in_ready         request handshake (ready only when idle)
//   out_data/out_idx/out_last slice, its index, final-beat flag
//   out_valid/out_ready       beat handshake
//   busy                      request in progress
module bit_scan_mux #(
   parameter int IWIDTH = 64,
   parameter int OWIDTH = 1,
   parameter int SELW   = $clog2(IWIDTH / OWIDTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [IWIDTH-1:0] in_data,
   input  logic              in_mode,
   input  logic [SELW-1:0]   in_sel,
   input  logic [SELW:0]     in_count,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [OWIDTH-1:0] out_data,
   output logic [SELW-1:0]   out_idx,
   output logic              out_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy
);

   typedef enum logic {
      S_IDLE,
      S_SCAN
   } state_t;

   // BEATS = 2**SELW, expressed in the width of the remaining counter
   localparam logic [SELW:0] BEATS = {1'b1, {SELW{1'b0}}};

   state_t            r_state;
   logic [IWIDTH-1:0] r_word;
   logic [SELW-1:0]   r_ptr;
   logic [SELW:0]     r_rem;
   logic [OWIDTH-1:0] r_data;
   logic              r_last;
   logic              r_valid;
   logic              r_busy;

   logic [SELW:0]     w_req_n;
   logic [SELW-1:0]   w_nptr;
   logic [OWIDTH-1:0] w_in_slice;
   logic [OWIDTH-1:0] w_nx_slice;

   function automatic logic [OWIDTH-1:0] f_slice(
      input logic [IWIDTH-1:0] w,
      input logic [SELW-1:0]   p
   );
      logic [IWIDTH-1:0] s;
      s = w >> (int'(p) * OWIDTH);
      return s[OWIDTH-1:0];
   endfunction

   // in_count[SELW] set means count >= BEATS; together with 0 both
   // select a full scan
   always_comb begin
      w_req_n = in_count;
      if (!in_mode)
         w_req_n = (SELW+1)'(1);
      else if (in_count == '0 || in_count[SELW])
         w_req_n = BEATS;
   end

   // pointer wraps naturally by truncation to SELW bits
   assign w_nptr     = r_ptr + 1'b1;
   assign w_in_slice = f_slice(in_data, in_sel);
   assign w_nx_slice = f_slice(r_word, w_nptr);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_word  <= '0;
         r_ptr   <= '0;
         r_rem   <= '0;
         r_data  <= '0;
         r_last  <= 1'b0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_state <= S_SCAN;
                  r_word  <= in_data;
                  r_ptr   <= in_sel;
                  r_rem   <= w_req_n;
                  r_data  <= w_in_slice;
                  r_last  <= (w_req_n == (SELW+1)'(1));
                  r_valid <= 1'b1;
                  r_busy  <= 1'b1;
               end
            end
            S_SCAN: begin
               if (out_ready) begin
                  if (r_last) begin
                     r_state <= S_IDLE;
                     r_last  <= 1'b0;
                     r_valid <= 1'b0;
                     r_busy  <= 1'b0;
                  end else begin
                     r_ptr  <= w_nptr;
                     r_rem  <= r_rem - 1'b1;
                     r_data <= w_nx_slice;
                     r_last <= (r_rem == (SELW+1)'(2));
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = rst_n && (r_state == S_IDLE);
   assign out_data  = r_data;
   assign out_idx   = r_ptr;
   assign out_last  = r_last;
   assign out_valid = r_valid;
   assign busy      = r_busy;

endmodule
